pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline. Drives enable/flush on the PC and on the
//   IF/ID, ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and squashes taken-branch
//   wrong-path fetches. Runs a req/ready handshake with a variable-latency data memory and freezes
//   the pipe until the access completes. A wait that never completes ends in a sticky error state.
// PARAMETERS
//   MEM_TIMEOUT  255  max MEM_WAIT cycles before entering ERROR (1..65535)
//   CNT_W        16   width of the saturating stall_count performance counter
// PORTS
//   clk            in   1      clock, rising edge
//   reset          in   1      asynchronous, active-high
//   id_rs          in   5      rs of instruction in ID
//   id_rt          in   5      rt of instruction in ID
//   id_uses_rt     in   1      ID instruction reads rt
//   id_branch_taken in  1      branch/jump resolved taken in ID
//   ex_MemRead     in   1      ID/EX MemRead (load in EX)
//   ex_WriteReg    in   5      ID/EX destination register
//   mem_MemRead    in   1      EX/MEM MemRead_out
//   mem_MemWrite   in   1      EX/MEM MemWrite_out
//   dmem_ready     in   1      data memory completes access this cycle
//   dmem_req       out  1      data memory request (level)
//   pc_en          out  1      PC write enable
//   ifid_en, ifid_flush      out 1 each  IF/ID control
//   idex_en, idex_flush      out 1 each  ID/EX control
//   exmem_en, exmem_flush    out 1 each  EX/MEM control
//   memwb_en, memwb_flush    out 1 each  MEM/WB control
//   mem_timeout    out  1      sticky error flag
//   stall_count    out  CNT_W  cycles with pc_en=0, saturating
// BEHAVIOUR
//   - FSM states: RUN, MEM_WAIT, ERROR. On reset: state=RUN, wait_cnt=0, stall_count=0,
//     mem_timeout=0. Outputs are combinational from state and inputs (RUN equations apply during reset).
//   - mem_acc = mem_MemRead | mem_MemWrite.
//   - dmem_req = mem_acc in RUN and MEM_WAIT; 0 in ERROR. An access completes on the clk edge
//     where dmem_req & dmem_ready. dmem_ready without dmem_req is ignored.
//   - Priority per cycle: ERROR > memory stall > load-use stall > branch flush > normal.
//   - Memory stall (mem_acc & ~dmem_ready, in RUN or MEM_WAIT):
//     pc/ifid/idex/exmem en=0, flushes=0; memwb_en=1 and memwb_flush=1 (bubble to WB).
//     RUN -> MEM_WAIT.
//   - Zero-wait access (mem_acc & dmem_ready in RUN): no stall; stays in RUN.
//   - MEM_WAIT: wait_cnt increments each cycle (starts 0 on entry). On dmem_ready: all en=1,
//     -> RUN, wait_cnt=0. If wait_cnt == MEM_TIMEOUT-1 and ~dmem_ready: -> ERROR. Ready wins
//     if both occur in the same cycle.
//   - Load-use (RUN, no mem stall):
//       ex_MemRead & ex_WriteReg!=0 &
//       (ex_WriteReg==id_rs | (id_uses_rt & ex_WriteReg==id_rt))
//     Outputs: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem/memwb advance.
//     Exactly 1 bubble per hazard.
//   - Branch (RUN, no stall): id_branch_taken -> ifid_en=1, ifid_flush=1; all others advance.
//     Branch + load-use in the same cycle: load-use wins. The branch is re-evaluated next cycle
//     because ID is held.
//   - Normal: all en=1, all flush=0.
//   - ERROR: all en=0, all flush=0, dmem_req=0, mem_timeout=1. Exit only via reset.
//   - stall_count: +1 on every clk edge with pc_en=0 (includes ERROR); saturates at 2^CNT_W-1.
//   - Reset mid-MEM_WAIT: immediate return to RUN with counters cleared; no request is
//     remembered.
// TESTING
//   1. Reset, idle inputs -> all en=1, flushes=0, dmem_req=0, mem_timeout=0, stall_count=0.
//   2. ex_MemRead=1, ex_WriteReg=5, id_rs=5 for 1 cycle -> pc_en=ifid_en=0, idex_flush=1;
//      stall_count=1. Repeat with ex_WriteReg=0 -> no stall.
//   3. mem_MemRead=1, dmem_ready low 3 cycles then high -> 3 freeze cycles with memwb_flush=1;
//      dmem_req high 4 cycles; all en=1 in cycle 4; state RUN.
//   4. MEM_TIMEOUT=4, mem_MemWrite=1, dmem_ready never -> ERROR after 4 wait cycles;
//      mem_timeout=1, dmem_req=0. Reset -> RUN, mem_timeout=0.
//   5. Load-use and id_branch_taken together -> no ifid_flush that cycle; branch held -> next
//      cycle ifid_flush=1.
//   6. CNT_W=4, 20 stall cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Ports: clk, reset (async, high); hazard inputs id_*/ex_*/mem_*;
//   dmem_ready/dmem_req handshake; per-stage en/flush outputs;
//   mem_timeout sticky flag; stall_count saturating counter.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_branch_taken,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_WriteReg,
   input  logic             mem_MemRead,
   input  logic             mem_MemWrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             memwb_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state, nxt;
   logic [15:0] wait_cnt;
   logic        mem_acc, mem_stall, load_use;

   assign mem_acc   = mem_MemRead | mem_MemWrite;
   assign mem_stall = mem_acc & ~dmem_ready;
   assign load_use  = ex_MemRead & (ex_WriteReg != 5'd0) &
                      ((ex_WriteReg == id_rs) |
                       (id_uses_rt & (ex_WriteReg == id_rt)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= nxt;
      end
   end

   // Counts consecutive MEM_WAIT cycles; zero on every other path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == MEM_WAIT && nxt == MEM_WAIT) begin
         wait_cnt <= wait_cnt + 16'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (!pc_en && stall_count != {CNT_W{1'b1}}) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   always_comb begin
      nxt         = state;
      dmem_req    = mem_acc;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      exmem_flush = 1'b0;
      memwb_en    = 1'b1;
      memwb_flush = 1'b0;
      mem_timeout = 1'b0;
      case (state)
         RUN, MEM_WAIT: begin
            if (mem_stall) begin
               // Front of pipe frozen; WB receives a bubble.
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
               if (state == RUN) begin
                  nxt = MEM_WAIT;
               end else if (wait_cnt == WAIT_LAST) begin
                  nxt = ERROR;
               end
            end else if (state == MEM_WAIT) begin
               nxt = RUN;
            end else if (load_use) begin
               // ID held, bubble into EX; a branch in ID retries next cycle.
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end else if (id_branch_taken) begin
               ifid_flush = 1'b1;
            end
         end
         ERROR: begin
            dmem_req    = 1'b0;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            mem_timeout = 1'b1;
         end
         default: nxt = RUN;
      endcase
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Expected outputs queued at drive time, compared on the falling edge.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_WriteReg = '0;
   logic       id_uses_rt = 1'b0, id_branch_taken = 1'b0;
   logic       ex_MemRead = 1'b0, mem_MemRead = 1'b0;
   logic       mem_MemWrite = 1'b0, dmem_ready = 1'b0;
   logic       dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic       exmem_en, exmem_flush, memwb_en, memwb_flush, mem_timeout;
   logic [3:0] stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      tag;
      logic [10:0] o;
      logic [3:0]  c;
   } exp_t;

   exp_t sb[$];

   // {req,pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb_en,memwb_fl,tmo}
   localparam logic [10:0] NRM = 11'b0_1_1_0_1_0_1_0_1_0_0;
   localparam logic [10:0] NRQ = 11'b1_1_1_0_1_0_1_0_1_0_0;
   localparam logic [10:0] MST = 11'b1_0_0_0_0_0_0_0_1_1_0;
   localparam logic [10:0] LU  = 11'b0_0_0_0_1_1_1_0_1_0_0;
   localparam logic [10:0] BR  = 11'b0_1_1_1_1_0_1_0_1_0_0;
   localparam logic [10:0] BRQ = 11'b1_1_1_1_1_0_1_0_1_0_0;
   localparam logic [10:0] ERR = 11'b0_0_0_0_0_0_0_0_0_0_1;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch_taken(id_branch_taken),
      .ex_MemRead(ex_MemRead), .ex_WriteReg(ex_WriteReg),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
      .dmem_ready(dmem_ready), .dmem_req(dmem_req),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .exmem_flush(exmem_flush),
      .memwb_en(memwb_en), .memwb_flush(memwb_flush),
      .mem_timeout(mem_timeout), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.tag, "/out"},
             32'({dmem_req, pc_en, ifid_en, ifid_flush, idex_en,
                  idex_flush, exmem_en, exmem_flush, memwb_en,
                  memwb_flush, mem_timeout}), 32'(e.o));
         chk({e.tag, "/cnt"}, 32'(stall_count), 32'(e.c));
      end
   end

   task automatic step(input string tag, input logic rst,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic br,
                       input logic exr, input logic [4:0] wr,
                       input logic mr, input logic mw, input logic rdy,
                       input logic [10:0] o, input logic [3:0] c);
      exp_t e;
      @(posedge clk);
      #1;
      reset           = rst;
      id_rs           = rs;
      id_rt           = rt;
      id_uses_rt      = urt;
      id_branch_taken = br;
      ex_MemRead      = exr;
      ex_WriteReg     = wr;
      mem_MemRead     = mr;
      mem_MemWrite    = mw;
      dmem_ready      = rdy;
      e.tag = tag;
      e.o   = o;
      e.c   = c;
      sb.push_back(e);
   endtask

   task automatic idle(input string tag, input logic [3:0] c);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, c);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset and idle
      step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
      step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
      idle("idle0", 0);
      // load-use via rs, via rt, and non-hazards
      step("lu_rs", 0, 5, 0, 0, 0, 1, 5, 0, 0, 0, LU, 0);
      idle("after_lu", 1);
      step("lu_r0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NRM, 1);
      step("lu_rt", 0, 3, 7, 1, 0, 1, 7, 0, 0, 0, LU, 1);
      idle("after_rt", 2);
      step("no_urt", 0, 3, 7, 0, 0, 1, 7, 0, 0, 0, NRM, 2);
      // memory stall outranks load-use and branch
      step("mst1", 0, 5, 0, 0, 1, 1, 5, 1, 0, 0, MST, 2);
      step("mst2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MST, 3);
      step("mst3", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MST, 4);
      step("mdone", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, NRQ, 5);
      idle("run_back", 5);
      // zero-wait access with a taken branch
      step("zw_br", 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, BRQ, 5);
      // load-use beats branch; branch retried next cycle
      step("lu_br", 0, 5, 0, 0, 1, 1, 5, 0, 0, 0, LU, 5);
      step("br_held", 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, BR, 6);
      idle("idle1", 6);
      step("rdy_only", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 6);
      // timeout: one RUN stall cycle plus four MEM_WAIT cycles
      for (int i = 0; i < 5; i++)
         step($sformatf("tmo%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              MST, 4'(6 + i));
      step("err_rdy", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ERR, 11);
      // ERROR is sticky; counter saturates at 15
      for (int i = 0; i < 12; i++)
         step($sformatf("err%0d", i), 0, 5, 0, 0, 1, 1, 5, 0, 1, 0,
              ERR, (12 + i > 15) ? 4'd15 : 4'(12 + i));
      step("rst_err", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
      idle("post_err", 0);
      // reset in the middle of a wait
      step("mw_a", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 0);
      step("mw_b", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 1);
      step("rst_mw", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
      idle("post_mw", 0);
      step("zw_rd", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, NRQ, 0);
      idle("final", 0);
      repeat (3) @(posedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
